// File: rtl/dm_resp.sv
// dm_resp: request/acknowledge responder around a word-organised data memory.
// Serves one byte/half/word access at a time; sub-word stores use read-modify-write.
module dm_resp #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wen,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [ADDR_W-1:0] add,
    input  logic [31:0]       data_in,
    output logic              ack,
    output logic              err,
    output logic [31:0]       data_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t             state_q, state_d;
    logic               err_q, err_d;
    logic [31:0]        data_out_q, data_out_d;

    logic               wen_q, wen_d;
    logic               sgn_q, sgn_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         lane_q, lane_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        rd_q;
    logic [IDX_W-1:0]   rd_idx;
    logic               mem_we;
    logic [31:0]        mem_wdata;

    function automatic logic access_bad(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] word_idx;
        logic              misaligned;
        word_idx   = a >> 2;
        misaligned = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        return (sz == 2'b11) || misaligned || (word_idx >= ADDR_W'(DEPTH));
    endfunction

    // Bit offset of the addressed lane group inside the word (little-endian).
    function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return {lane, 3'b000};
            2'b01:   return {lane[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] lane, input logic s);
        logic [31:0] sh;
        sh = word >> lane_shift(sz, lane);
        case (sz)
            2'b00:   return {{24{s & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{s & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] nw,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] mask;
        logic [4:0]  sh;
        sh = lane_shift(sz, lane);
        case (sz)
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << sh;
        return (old & ~mask) | ((nw << sh) & mask);
    endfunction

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        data_out_d = data_out_q;
        wen_d      = wen_q;
        sgn_d      = sgn_q;
        size_d     = size_q;
        lane_d     = lane_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wen_d   = wen;
                    sgn_d   = sgn;
                    size_d  = size;
                    lane_d  = add[1:0];
                    idx_d   = add[IDX_W+1:2];
                    wdata_d = data_in;
                    err_d   = access_bad(size, add);
                    if (err_d) begin
                        data_out_d = '0;
                        state_d    = RESP;
                    end else if (wen && size == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (wen_q) begin
                    state_d = WRITE;
                end else begin
                    data_out_d = load_fmt(rd_q, size_q, lane_q, sgn_q);
                    state_d    = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAM is read from the incoming address while idle so the word is ready in READ.
    assign rd_idx    = (state_q == IDLE) ? add[IDX_W+1:2] : idx_q;
    assign mem_we    = (state_q == WRITE) && !rst;
    assign mem_wdata = store_merge(rd_q, wdata_q, size_q, lane_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        wen_q   <= wen_d;
        sgn_q   <= sgn_d;
        size_q  <= size_d;
        lane_q  <= lane_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= mem_wdata;
        end
        rd_q <= mem[rd_idx];
    end

    assign ack      = (state_q == RESP);
    assign err      = ack && err_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_dm_resp.sv
// Testbench for dm_resp: directed transactions checked against a byte-addressed memory model.
module tb_dm_resp;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        wen = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sgn = 1'b0;
    logic [31:0] add = '0;
    logic [31:0] data_in = '0;
    logic        ack;
    logic        err;
    logic [31:0] data_out;

    dm_resp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .wen(wen), .size(size), .sgn(sgn),
        .add(add), .data_in(data_in), .ack(ack), .err(err), .data_out(data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model state: byte memory plus the expectation for the transaction in flight.
    logic [7:0]  mb [4*DEPTH];
    int          exp_ack_cyc = -1;
    logic        exp_err = 1'b0;
    logic        exp_upd = 1'b0;
    logic [31:0] exp_load = '0;
    logic [31:0] cur_dout = '0;
    logic        exp_ack;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_dout", data_out, 32'd0);
            cur_dout = '0;
        end else begin
            exp_ack = (cyc == exp_ack_cyc);
            chk("ack", 32'(ack), 32'(exp_ack));
            if (exp_ack) begin
                chk("err", 32'(err), 32'(exp_err));
                if (exp_upd) cur_dout = exp_load;
            end
            chk("dout", data_out, cur_dout);
        end
    end

    task automatic setexp(input logic w, input logic [1:0] sz, input logic s, input logic [31:0] a,
                          input logic [31:0] d, input bit commit, input int base);
        int          n;
        bit          bad;
        logic [31:0] v;
        n   = 1 << sz;
        bad = (sz == 2'b11) || ((a % n) != 0) || (a >= 32'(4*DEPTH));
        v   = '0;
        if (!bad && !w) begin
            for (int i = 0; i < n; i++) v = v | (32'(mb[a+i]) << (8*i));
            if (s && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        end
        if (!bad && w && commit) begin
            for (int i = 0; i < n; i++) mb[a+i] = 8'(d >> (8*i));
        end
        exp_err     = bad;
        exp_upd     = bad || !w;
        exp_load    = bad ? 32'd0 : v;
        exp_ack_cyc = base + (bad ? 1 : (!w ? 2 : (n == 4 ? 2 : 3)));
    endtask

    task automatic start(input logic w, input logic [1:0] sz, input logic s, input logic [31:0] a,
                         input logic [31:0] d, input bit commit);
        @(negedge clk); #1;
        req = 1'b1; wen = w; size = sz; sgn = s; add = a; data_in = d;
        setexp(w, sz, s, a, d, commit, cyc);
    endtask

    task automatic wait_ack(input string nm, input int lit_lat);
        bit got;
        int st;
        got = 1'b0;
        st  = cyc;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk); #1;
            if (ack) got = 1'b1;
        end
        chk({nm, "_ack_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(cyc - st), 32'(lit_lat));
    endtask

    task automatic txn(input string nm, input logic w, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input int lit_lat,
                       input bit use_lit, input logic [31:0] lit);
        start(w, sz, s, a, d, 1'b1);
        wait_ack(nm, lit_lat);
        if (use_lit) chk({nm, "_data"}, data_out, lit);
        req = 1'b0;
    endtask

    int first_ack;
    bit got2;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        txn("st_w8",   1, 2'b10, 0, 32'h8,  32'hDEADBEEF, 2, 0, 32'h0);
        txn("ld_w8",   0, 2'b10, 0, 32'h8,  32'h0,        2, 1, 32'hDEADBEEF);
        txn("st_b9",   1, 2'b00, 0, 32'h9,  32'h0000005A, 3, 0, 32'h0);
        txn("ld_w8b",  0, 2'b10, 0, 32'h8,  32'h0,        2, 1, 32'hDEAD5AEF);
        txn("st_w10",  1, 2'b10, 0, 32'h10, 32'h000080FF, 2, 0, 32'h0);
        txn("ld_sb11", 0, 2'b00, 1, 32'h11, 32'h0,        2, 1, 32'hFFFFFF80);
        txn("ld_ub11", 0, 2'b00, 0, 32'h11, 32'h0,        2, 1, 32'h00000080);
        txn("ld_sh10", 0, 2'b01, 1, 32'h10, 32'h0,        2, 1, 32'hFFFF80FF);
        txn("ld_uh12", 0, 2'b01, 0, 32'h12, 32'h0,        2, 1, 32'h00000000);
        txn("st_w0",   1, 2'b10, 0, 32'h0,  32'h11223344, 2, 0, 32'h0);
        txn("st_h2",   1, 2'b01, 0, 32'h2,  32'h0000ABCD, 3, 0, 32'h0);
        txn("ld_w0",   0, 2'b10, 0, 32'h0,  32'h0,        2, 1, 32'hABCD3344);

        // Rejected accesses, each followed by a load proving memory is untouched.
        txn("e_h3",    1, 2'b01, 0, 32'h3,  32'h00001234, 1, 1, 32'h0);
        txn("chk_e1",  0, 2'b10, 0, 32'h0,  32'h0,        2, 1, 32'hABCD3344);
        txn("e_w2",    0, 2'b10, 0, 32'h2,  32'h0,        1, 1, 32'h0);
        txn("chk_e2",  0, 2'b10, 0, 32'h0,  32'h0,        2, 1, 32'hABCD3344);
        txn("e_sz3",   1, 2'b11, 0, 32'h8,  32'hFFFFFFFF, 1, 1, 32'h0);
        txn("chk_e3",  0, 2'b10, 0, 32'h8,  32'h0,        2, 1, 32'hDEAD5AEF);
        txn("e_range", 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 1, 1, 32'h0);
        txn("chk_e4",  0, 2'b10, 0, 32'h0,  32'h0,        2, 1, 32'hABCD3344);

        // Reset in the WRITE cycle of a byte store: no write, no acknowledge.
        txn("st_w20",  1, 2'b10, 0, 32'h20, 32'hAABBCCDD, 2, 0, 32'h0);
        start(1, 2'b00, 0, 32'h20, 32'h00000011, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1; req = 1'b0; exp_ack_cyc = -1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        txn("ld_w20",  0, 2'b10, 0, 32'h20, 32'h0,        2, 1, 32'hAABBCCDD);

        // req held high across two word loads; mid-transaction input changes are ignored.
        start(0, 2'b10, 0, 32'h8, 32'h0, 1'b1);
        @(negedge clk); #1;
        wen = 1'b1; size = 2'b00; sgn = 1'b1; add = 32'h10; data_in = 32'h55555555;
        @(negedge clk); #1;
        chk("b2b_ack1", 32'(ack), 32'd1);
        chk("b2b_data1", data_out, 32'hDEAD5AEF);
        first_ack = cyc;
        wen = 1'b0; size = 2'b10; sgn = 1'b0; add = 32'h10; data_in = 32'h0;
        setexp(0, 2'b10, 0, 32'h10, 32'h0, 1'b1, cyc + 1);
        got2 = 1'b0;
        for (int i = 0; i < 8 && !got2; i++) begin
            @(negedge clk); #1;
            if (ack) got2 = 1'b1;
        end
        chk("b2b_ack2_seen", 32'(got2), 32'd1);
        chk("b2b_gap", 32'(cyc - first_ack), 32'd3);
        chk("b2b_data2", data_out, 32'h000080FF);
        req = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
